// File: rtl/dmi_initiator.sv
// DTM-side master of the DMI trivial bus: one bus transaction per JTAG request, sticky busy/failed status.
// Optional DMI_TIMEOUT_EN aborts a transaction whose dmi_finish does not arrive within TIMEOUT_CYCLES.
module dmi_initiator #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [1:0]   req_op,
  input  logic [6:0]   req_addr,
  input  logic [31:0]  req_data,
  input  logic         dmireset,
  input  logic         dmihardreset,
  output logic         rsp_valid,
  output logic [1:0]   rsp_op,
  output logic [31:0]  rsp_data,
  output logic         busy,
  output logic         dmi_start,
  input  logic         dmi_finish,
  output logic [1:0]   dmi_op,
  output logic [33:2]  dmi_data_o,
  input  logic [33:2]  dmi_data_i,
  output logic [40:34] dmi_address
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dmi_initiator: TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0] state;
  logic [1:0] sticky;
  logic       tmo_hit;
  logic       err_set;
  logic [1:0] err_code;

`ifdef DMI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Expire in the WAIT cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit = (state == S_WAIT) && !dmi_finish &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_set  = 1'b0;
    err_code = ST_OK;
    if (req_valid && state != S_IDLE) begin
      err_set  = 1'b1;
      err_code = ST_BUSY;
    end else if (req_valid && sticky == ST_OK && req_op == 2'd3) begin
      err_set  = 1'b1;
      err_code = ST_FAILED;
    end
    if (tmo_hit) begin
      err_set  = 1'b1;
      err_code = ST_FAILED;
    end
  end

  // First error wins; either reset flavour overrides a coincident error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= ST_OK;
    end else if (dmihardreset || dmireset) begin
      sticky <= ST_OK;
    end else if (err_set && sticky == ST_OK) begin
      sticky <= err_code;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      dmi_op      <= '0;
      dmi_address <= '0;
      dmi_data_o  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (dmihardreset) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              if (sticky == ST_OK && (req_op == 2'd1 || req_op == 2'd2)) begin
                dmi_op      <= req_op;
                dmi_address <= req_addr;
                dmi_data_o  <= req_data;
                state       <= S_START;
              end else begin
                rsp_valid <= 1'b1;
              end
            end
          end
          S_START: state <= S_WAIT;
          S_WAIT: begin
            if (dmi_finish) begin
              rsp_data  <= dmi_data_i;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else if (tmo_hit) begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign dmi_start = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign rsp_op    = sticky;

endmodule

// File: tb/tb_dmi_initiator.sv
// Randomized self-checking bench for dmi_initiator against a transaction-level model and a simple DM.
// Build with +define+DMI_TIMEOUT_EN to exercise the timeout path.
module tb_dmi_initiator;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic        busy;
  logic        dmi_start;
  logic        dmi_finish = 1'b0;
  logic [1:0]  dmi_op;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i;
  logic [6:0]  dmi_address;

  dmi_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .dmireset(dmireset), .dmihardreset(dmihardreset),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_data(rsp_data), .busy(busy),
    .dmi_start(dmi_start), .dmi_finish(dmi_finish), .dmi_op(dmi_op),
    .dmi_data_o(dmi_data_o), .dmi_data_i(dmi_data_i), .dmi_address(dmi_address)
  );

  always #5 clk = ~clk;

  // Debug module model: register file, finishes dm_lat cycles after start (0 = never).
  logic [31:0] dm_mem [128];
  int          dm_lat = 2;
  int          fin_timer = 0;
  logic        fin_inject = 1'b0;

  assign dmi_data_i = dm_mem[dmi_address];

  always @(negedge clk) begin
    if (dmi_start) begin
      fin_timer = dm_lat;
      if (dmi_op == 2'd2) dm_mem[dmi_address] = dmi_data_o;
    end else if (fin_timer > 0) begin
      fin_timer = fin_timer - 1;
    end
  end

  always @(posedge clk) begin
    #2;
    dmi_finish = (fin_timer == 1) || fin_inject;
  end

  // Reference model state
  logic [31:0] ref_mem [128];
  logic [1:0]  m_sticky = 2'd0;
  logic [31:0] m_rsp_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_dmireset();
    @(posedge clk); #1 dmireset = 1'b1;
    @(posedge clk); #1 dmireset = 1'b0;
    m_sticky = 2'd0;
    @(negedge clk);
    check("dmireset_sticky", 32'(rsp_op), 32'(m_sticky));
  endtask

  // Issue one request; extra_at > 0 re-pulses req_valid that many cycles later (must land while busy).
  task automatic run_req(input string tag, input logic [1:0] op, input logic [6:0] addr,
                         input logic [31:0] data, input int lat, input int extra_at);
    bit          bus;
    int          exp_rsp_cyc;
    logic [31:0] exp_data;
    int          starts = 0;
    int          start_cyc = -1;
    int          rsp_cyc = -1;
    logic [1:0]  seen_op = '0;
    logic [31:0] seen_data = '0;
    bit          stable = 1'b1;
    bit          fields_ok = 1'b0;

    bus = (m_sticky == 2'd0) && (op == 2'd1 || op == 2'd2);
    if (bus) begin
      if (op == 2'd2) ref_mem[addr] = data;
      if (lat == 0) begin
        exp_data    = m_rsp_data;
        exp_rsp_cyc = TMO + 2;
        if (m_sticky == 2'd0) m_sticky = 2'd2;
      end else begin
        exp_data    = ref_mem[addr];
        exp_rsp_cyc = lat + 2;
      end
      if (extra_at > 0 && m_sticky == 2'd0) m_sticky = 2'd3;
    end else begin
      exp_data    = m_rsp_data;
      exp_rsp_cyc = 1;
      if (m_sticky == 2'd0 && op == 2'd3) m_sticky = 2'd2;
    end
    m_rsp_data = exp_data;
    dm_lat = lat;

    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    for (int k = 1; k <= exp_rsp_cyc + 4; k++) begin
      @(posedge clk); #1;
      req_valid = bus && (extra_at > 0) && (k == extra_at);
      @(negedge clk);
      if (dmi_start) begin
        starts++;
        start_cyc = k;
        fields_ok = (dmi_address == addr) && (dmi_op == op) && (dmi_data_o == data);
      end
      if (bus && busy && (dmi_address != addr || dmi_op != op || dmi_data_o != data)) stable = 1'b0;
      if (rsp_valid) begin
        if (rsp_cyc == -1) begin
          rsp_cyc = k; seen_op = rsp_op; seen_data = rsp_data;
        end else begin
          rsp_cyc = -2;
        end
      end
    end
    req_valid = 1'b0;

    check({tag, "_starts"}, 32'(starts), bus ? 32'd1 : 32'd0);
    if (bus) begin
      check({tag, "_start_cyc"}, 32'(start_cyc), 32'd1);
      check({tag, "_start_fields"}, 32'(fields_ok), 32'd1);
      check({tag, "_addr_stable"}, 32'(stable), 32'd1);
    end
    check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'(exp_rsp_cyc));
    check({tag, "_rsp_op"}, 32'(seen_op), 32'(m_sticky));
    check({tag, "_rsp_data"}, seen_data, exp_data);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int starts;
    int busy_low;
    for (int i = 0; i < 128; i++) begin
      dm_mem[i]  = $urandom;
      ref_mem[i] = dm_mem[i];
    end
    dm_mem[7'h11]  = 32'h0000_0C82;
    ref_mem[7'h11] = 32'h0000_0C82;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dmi_start", 32'(dmi_start), 32'd0);
    check("rst_dmi_bus", {dmi_op, dmi_address, 23'd0}, 32'd0);
    check("rst_dmi_data_o", dmi_data_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed scenarios
    run_req("write", 2'd2, 7'h04, 32'hDEAD_BEEF, 2, 0);
    run_req("read", 2'd1, 7'h11, 32'h0, 2, 0);
    run_req("busy", 2'd1, 7'h20, 32'h1234_5678, 2, 1);
    run_req("sticky_ign", 2'd1, 7'h21, 32'h0, 2, 0);
    pulse_dmireset();
    run_req("read_after_rst", 2'd1, 7'h11, 32'h0, 3, 0);
    run_req("reserved", 2'd3, 7'h05, 32'h0, 2, 0);
    pulse_dmireset();
    run_req("nop", 2'd0, 7'h05, 32'h0, 2, 0);

    // Hardreset in WAIT with a late finish; a busy error set earlier must be cleared.
    dm_lat = 0;
    @(posedge clk); #1 req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h05;
    @(posedge clk); #1 req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 dmihardreset = 1'b1;
    @(negedge clk);
    check("hr_pre_sticky", 32'(rsp_op), 32'd3);
    @(posedge clk); #1 dmihardreset = 1'b0; fin_inject = 1'b1;
    @(negedge clk);
    check("hr_busy", 32'(busy), 32'd0);
    check("hr_no_rsp", 32'(rsp_valid), 32'd0);
    check("hr_sticky", 32'(rsp_op), 32'd0);
    starts = dmi_start ? 1 : 0;
    @(posedge clk); #1 fin_inject = 1'b0;
    @(negedge clk);
    starts += dmi_start ? 1 : 0;
    check("hr_late_fin_rsp", 32'(rsp_valid), 32'd0);
    check("hr_no_start", 32'(starts), 32'd0);
    check("hr_rsp_data", rsp_data, m_rsp_data);
    m_sticky = 2'd0;

`ifdef DMI_TIMEOUT_EN
    run_req("timeout", 2'd1, 7'h09, 32'h0, 0, 0);
    pulse_dmireset();
`else
    // Without the timeout a silent DM keeps the transaction open until hardreset.
    dm_lat = 0;
    @(posedge clk); #1 req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h09;
    @(posedge clk); #1 req_valid = 1'b0;
    busy_low = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    check("no_tmo_busy_held", 32'(busy_low), 32'd0);
    @(posedge clk); #1 dmihardreset = 1'b1;
    @(posedge clk); #1 dmihardreset = 1'b0;
    @(negedge clk);
    check("no_tmo_hr_busy", 32'(busy), 32'd0);
    check("no_tmo_hr_sticky", 32'(rsp_op), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          r;
      int          lat;
      int          extra;
      logic [1:0]  op;
      r = $urandom_range(0, 9);
      if (r == 0 || (m_sticky != 2'd0 && r < 4)) begin
        pulse_dmireset();
      end else begin
        r = $urandom_range(0, 9);
        op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
        lat = $urandom_range(1, 4);
        extra = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat + 1) : 0;
        run_req("rand", op, 7'($urandom_range(0, 127)), $urandom, lat, extra);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmi_initiator.md
Name: dmi_initiator

Overview:
- Single-hart debug path: the DTM-side master of the DMI trivial bus, driving the debug module's dmi_start, dmi_op, dmi_address and dmi_data_o, and sampling its dmi_finish and dmi_data_i.
- Accepts one-cycle request pulses from the already-synchronized JTAG dmi register update logic.
- Sequences exactly one bus transaction per request and returns a status/data response for the next JTAG capture.
- Implements DTM sticky-error semantics (busy/failed) with dmireset and dmihardreset.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for dmi_finish after dmi_start before aborting (only with DMI_TIMEOUT_EN); must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  one-cycle request pulse from the JTAG update logic.
- req_op  input  2  0 nop, 1 read, 2 write, 3 reserved.
- req_addr  input  7  DM register address.
- req_data  input  32  write data.
- dmireset  input  1  pulse; clears the sticky status.
- dmihardreset  input  1  pulse; aborts the in-flight transaction and clears the sticky status.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_op  output  2  0 ok, 2 failed, 3 busy; holds the sticky status.
- rsp_data  output  32  captured dmi_data_i; held until the next capture.
- busy  output  1  high while a transaction is in flight.
- dmi_start  output  1  one-cycle start pulse to the DM.
- dmi_finish  input  1  DM completion.
- dmi_op  output  2  bus op.
- dmi_data_o  output  [33:2]  write data to the DM.
- dmi_data_i  input  [33:2]  read data from the DM (combinational from dmi_address).
- dmi_address  output  [40:34]  bus address.

Behaviour:
- Reset: all outputs 0; sticky = 0; state IDLE.
- States:
  - IDLE: wait for a request.
  - START: dmi_start = 1 for exactly one cycle, then WAIT.
  - WAIT: on dmi_finish, capture dmi_data_i[33:2] into rsp_data and go to RESP; on timeout set sticky = 2 and go to RESP without capturing.
  - RESP: rsp_valid = 1 for one cycle, then IDLE.
- Request in IDLE with sticky == 0:
  - op 1 or 2: latch op/addr/data onto dmi_op/dmi_address/dmi_data_o and go to START.
  - Latency: request at cycle T gives dmi_start at T+1. With a DM finishing 2 cycles after start, dmi_finish is seen at T+3 and rsp_valid at T+4.
  - op 0: no bus activity; rsp_valid at T+1 with rsp_data unchanged.
  - op 3: no bus activity; set sticky = 2; rsp_valid at T+1.
- Request in IDLE with sticky != 0: ignored (no bus activity); rsp_valid at T+1 with rsp_op = sticky.
- Request while state != IDLE: dropped; sticky = 3 unless already nonzero (first error wins). The in-flight transaction completes normally.
- busy = 1 in START, WAIT and RESP.
- dmi_op, dmi_address and dmi_data_o remain stable from START until return to IDLE, then retain their last values. The DM decodes address combinationally, so address must not change before finish.
- dmi_start never asserts twice per request. It never asserts while state != START (the DM writes on every start cycle).
- dmi_finish outside WAIT is ignored.
- rsp_op always reflects the current sticky value.
- dmireset: sticky <= 0 next cycle; has no effect on an in-flight transaction. If it coincides with an error-setting event, dmireset wins.
- dmihardreset: next cycle state = IDLE, sticky = 0, dmi_start = 0, busy = 0, and no rsp_valid. A late dmi_finish is ignored. A req_valid in the same cycle is dropped.
- rst_n low mid-transaction: immediate return to reset values; no pulse is emitted.

Optional Feature:
- DMI_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without dmi_finish: sticky = 2, rsp_data unchanged, go to RESP.
  - dmi_finish in the same cycle as expiry counts as success.
- Undefined: no counter; WAIT persists until dmi_finish, dmihardreset or reset.

Test Plan:
- Write: req op=2 addr=0x04 data=0xDEADBEEF, DM model finishes 2 cycles after start -> one dmi_start pulse at T+1 with dmi_address=0x04, dmi_op=2, dmi_data_o=0xDEADBEEF; rsp_valid at T+4, rsp_op=0.
- Read: req op=1 addr=0x11, DM returns 0x00000C82 -> rsp_data=0x00000C82, rsp_op=0, address stable for the whole transaction.
- Busy: second req_valid 1 cycle after the first -> no second dmi_start, rsp_op=3. Next req op=1 -> no bus activity, rsp_op=3. After dmireset, req op=1 -> normal read, rsp_op=0.
- Reserved/nop: req op=3 -> rsp_valid at T+1, rsp_op=2, dmi_start never high. After dmireset, op=0 -> rsp_valid at T+1, rsp_op=0.
- Hardreset: dmihardreset during WAIT, then dmi_finish 1 cycle later -> busy=0, no rsp_valid, sticky=0, no extra dmi_start.
- Timeout (DMI_TIMEOUT_EN, TIMEOUT_CYCLES=64): DM never finishes -> rsp_valid 64 WAIT cycles after start, rsp_op=2. Same stimulus without the macro -> busy stays high for 200 cycles.
